// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between the
// in-order pipeline writeback and a buffered long-latency load unit.
// LU results queue in a small FIFO and drain into idle WB slots. An
// aging/occupancy FSM forces bounded drain bursts (stalling the pipeline)
// so queued results cannot starve. A hazard query reports whether any
// queued entry targets one of three decode addresses.
module rf_write_arbiter #(
  parameter int QDEPTH   = 4,
  parameter int MAX_WAIT = 8,
  parameter int DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wb_wr_en_i,
  input  logic [4:0]        wb_rd_addr_i,
  input  logic [DATA_W-1:0] wb_wr_data_i,
  input  logic              lu_valid_i,
  input  logic [4:0]        lu_rd_addr_i,
  input  logic [DATA_W-1:0] lu_data_i,
  output logic              lu_ready_o,
  output logic              rf_wr_en_o,
  output logic [4:0]        rf_wr_addr_o,
  output logic [DATA_W-1:0] rf_wr_data_o,
  output logic              pipe_stall_o,
  input  logic [4:0]        q_rs1_addr_i,
  input  logic [4:0]        q_rs2_addr_i,
  input  logic [4:0]        q_rd_addr_i,
  output logic              hazard_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] QDEPTH_C     = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0] DRAIN_LAST_C = CNT_W'(QDEPTH - 1);
  localparam logic [AGE_W-1:0] MAX_WAIT_C   = AGE_W'(MAX_WAIT);

  typedef enum logic [0:0] {
    PIPE_PRI = 1'b0,
    DRAIN    = 1'b1
  } state_e;

  // A queued destination matches a query address; x0 never creates a hazard.
  function automatic logic addr_hit(input logic [4:0] entry_rd, input logic [4:0] q_addr);
    return (q_addr != 5'd0) && (entry_rd == q_addr);
  endfunction

  state_e              state_r, state_next_s;
  logic [CNT_W-1:0]    count_r, count_next_s;
  logic [AGE_W-1:0]    age_r, age_next_s;
  logic [CNT_W-1:0]    drain_cnt_r, drain_cnt_next_s;
  logic [PTR_W-1:0]    rd_ptr_r, wr_ptr_r;
  logic [QDEPTH-1:0]   valid_r;
  logic [4:0]          rd_mem_r   [QDEPTH];
  logic [DATA_W-1:0]   data_mem_r [QDEPTH];

  logic wb_req_s;
  logic lu_ready_s;
  logic push_s;
  logic pop_s;
  logic grant_wb_s;
  logic stall_s;
  logic hazard_s;

  // x0 destinations are meaningless: a WB to x0 is no request, an LU beat to x0 is swallowed.
  assign wb_req_s   = wb_wr_en_i && (wb_rd_addr_i != 5'd0);
  assign lu_ready_s = (count_r < QDEPTH_C);
  assign push_s     = lu_valid_i && lu_ready_s && (lu_rd_addr_i != 5'd0);

  // Write-port arbitration: WB has priority in PIPE_PRI, FIFO head owns the port in DRAIN.
  always_comb begin
    grant_wb_s = 1'b0;
    pop_s      = 1'b0;
    stall_s    = 1'b0;
    case (state_r)
      PIPE_PRI: begin
        if (wb_req_s) begin
          grant_wb_s = 1'b1;
        end else if (count_r != '0) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      DRAIN: begin
        stall_s = 1'b1;
        if (count_r != '0) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      default: begin
        grant_wb_s = 1'b0;
        pop_s      = 1'b0;
        stall_s    = 1'b0;
      end
    endcase
  end

  // Next occupancy, head age and FSM/drain-burst bookkeeping.
  always_comb begin
    count_next_s     = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    age_next_s       = age_r;
    state_next_s     = state_r;
    drain_cnt_next_s = drain_cnt_r;

    if (pop_s || (count_r == '0)) begin
      age_next_s = '0;
    end else if ((state_r == PIPE_PRI) && (age_r < MAX_WAIT_C)) begin
      age_next_s = age_r + AGE_W'(1);
    end else begin
      age_next_s = age_r;
    end

    case (state_r)
      PIPE_PRI: begin
        if ((count_next_s == QDEPTH_C) || (age_next_s >= MAX_WAIT_C)) begin
          state_next_s     = DRAIN;
          drain_cnt_next_s = '0;
        end else begin
          state_next_s     = PIPE_PRI;
          drain_cnt_next_s = drain_cnt_r;
        end
      end
      DRAIN: begin
        // Leaving after QDEPTH grants bounds the stall even under continuous LU pushes.
        if ((count_next_s == '0) || (drain_cnt_r == DRAIN_LAST_C)) begin
          state_next_s     = PIPE_PRI;
          drain_cnt_next_s = '0;
        end else begin
          state_next_s     = DRAIN;
          drain_cnt_next_s = drain_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_next_s     = PIPE_PRI;
        drain_cnt_next_s = '0;
      end
    endcase
  end

  // Hazard: OR of address matches over entries currently held in the FIFO.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      hazard_s = hazard_s | (valid_r[i] & (addr_hit(rd_mem_r[i], q_rs1_addr_i) |
                                           addr_hit(rd_mem_r[i], q_rs2_addr_i) |
                                           addr_hit(rd_mem_r[i], q_rd_addr_i)));
    end
  end

  // Control state: FSM, occupancy, age, drain burst length and FIFO pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= PIPE_PRI;
      count_r     <= '0;
      age_r       <= '0;
      drain_cnt_r <= '0;
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
    end else begin
      state_r     <= state_next_s;
      count_r     <= count_next_s;
      age_r       <= age_next_s;
      drain_cnt_r <= drain_cnt_next_s;
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
    end
  end

  // FIFO storage; per-entry valid bits drive the hazard query.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        rd_mem_r[i]   <= 5'd0;
        data_mem_r[i] <= '0;
      end
    end else begin
      // Push and pop never share a slot: that needs empty (no pop) or full (no push).
      if (pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
      end
      if (push_s) begin
        valid_r[wr_ptr_r]    <= 1'b1;
        rd_mem_r[wr_ptr_r]   <= lu_rd_addr_i;
        data_mem_r[wr_ptr_r] <= lu_data_i;
      end
    end
  end

  // Write-port mux; address and data forced to zero when nothing is written or in reset.
  always_comb begin
    rf_wr_addr_o = 5'd0;
    rf_wr_data_o = '0;
    if (!rst_ni) begin
      rf_wr_addr_o = 5'd0;
      rf_wr_data_o = '0;
    end else if (grant_wb_s) begin
      rf_wr_addr_o = wb_rd_addr_i;
      rf_wr_data_o = wb_wr_data_i;
    end else if (pop_s) begin
      rf_wr_addr_o = rd_mem_r[rd_ptr_r];
      rf_wr_data_o = data_mem_r[rd_ptr_r];
    end else begin
      rf_wr_addr_o = 5'd0;
      rf_wr_data_o = '0;
    end
  end

  assign rf_wr_en_o   = rst_ni & (grant_wb_s | pop_s);
  assign pipe_stall_o = rst_ni & stall_s;
  assign lu_ready_o   = rst_ni & lu_ready_s;
  assign hazard_o     = rst_ni & hazard_s;

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback (WB stage output) and a long-latency load unit (LU) that returns results out of band. LU results are buffered in a small FIFO and drained into idle WB slots. An aging/occupancy FSM forces drain cycles and stalls the pipeline so the FIFO cannot starve. The block also gives decode a hazard query against pending (queued) destination registers.

Parameters:
QDEPTH, 4, LU result FIFO depth; power of 2, >=2
MAX_WAIT, 8, max cycles the FIFO head may wait ungranted before forced drain; >=1
DATA_W, 32, write data width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  reset, asynchronous, active-low
wb_wr_en_i  in  1  pipeline WB write request
wb_rd_addr_i  in  5  pipeline WB destination
wb_wr_data_i  in  DATA_W  pipeline WB data
lu_valid_i  in  1  LU result valid
lu_rd_addr_i  in  5  LU destination
lu_data_i  in  DATA_W  LU data
lu_ready_o  out  1  FIFO can accept; transfer when lu_valid_i & lu_ready_o
rf_wr_en_o  out  1  register-file write enable
rf_wr_addr_o  out  5  register-file write address
rf_wr_data_o  out  DATA_W  register-file write data
pipe_stall_o  out  1  freeze WB and earlier stages this cycle
q_rs1_addr_i  in  5  hazard query address 1
q_rs2_addr_i  in  5  hazard query address 2
q_rd_addr_i  in  5  hazard query address 3 (WAW check)
hazard_o  out  1  some valid FIFO entry targets a nonzero query address

Behaviour:
- State: FIFO (rd, data) x QDEPTH, count 0..QDEPTH, age counter, wrap-around rd/wr pointers, FSM {PIPE_PRI, DRAIN}, drain counter.
- Reset (async assert): FIFO empty, pointers/counters 0, FSM=PIPE_PRI. While rst_ni=0: rf_wr_en_o=0, rf_wr_addr_o=0, rf_wr_data_o=0, pipe_stall_o=0, lu_ready_o=0, hazard_o=0. Reset mid-drain discards all queued entries.
- Outputs rf_wr_*, pipe_stall_o and hazard_o are combinational from current state and inputs (0-cycle latency). A push is visible to hazard_o and can be granted from the next cycle.
- lu_ready_o = (count < QDEPTH); depends on count only, so no push on a full FIFO even if a pop occurs the same cycle.
- An LU transfer with lu_rd_addr_i=0 is accepted and discarded (no push). A WB request with wb_rd_addr_i=0 counts as no request.
- PIPE_PRI: if a WB request is present, grant WB, pipe_stall_o=0. Otherwise, if count>0, grant the FIFO head (pop). Otherwise rf_wr_en_o=0.
- DRAIN: pipe_stall_o=1. Grant the FIFO head every cycle (pop). The WB request is ignored and must be held by the stalled pipeline.
- Age: in PIPE_PRI with count>0 and head not granted, age++. Age clears on any pop or when count=0.
- PIPE_PRI -> DRAIN at the next edge if (count_next == QDEPTH) or (age_next >= MAX_WAIT). The drain counter loads 0.
- DRAIN -> PIPE_PRI at the next edge when count_next==0 or after QDEPTH consecutive drain grants. This bounds pipeline stall to QDEPTH cycles even with continuous LU pushes.
- Simultaneous push and pop: count unchanged; pointers both advance modulo QDEPTH.
- hazard_o: OR over valid entries of (entry.rd==addr && addr!=0) for the three query addresses. The incoming LU beat is not included.
- Write data passes unmodified. rf_wr_addr_o/rf_wr_data_o = 0 when rf_wr_en_o=0.

Test Plan:
- Reset: hold rst_ni=0 with lu_valid_i=1, wb_wr_en_i=1 -> all outputs 0. Release -> lu_ready_o=1, FSM PIPE_PRI.
- WB only: wb x5=0xDEADBEEF -> same cycle rf_wr_en_o=1, addr 5, data 0xDEADBEEF, pipe_stall_o=0.
- Idle-slot drain: push LU x7=0x11, x8=0x22 with WB idle -> writes x7 then x8 on the next two cycles. hazard_o=1 for q_rs1=7 until the x7 pop, then 0.
- Full -> DRAIN: QDEPTH=4, continuous WB writes, 4 LU pushes -> lu_ready_o=0 after the 4th push. Next cycle pipe_stall_o=1 for 4 cycles, pops in FIFO order, then back to PIPE_PRI.
- Aging: 1 LU push, continuous WB writes -> after MAX_WAIT=8 blocked cycles, one DRAIN cycle with stall, entry written, stall drops.
- Boundaries: LU push to x0 -> accepted, never written, hazard_o=0 for query 0. Assert rst_ni low mid-DRAIN with 3 entries -> queue empty, stall 0 immediately.
